montgomery_chunked: RTL and testbench

- Parametrised radix-2 Montgomery multiplier. Computes result = A·B·2^(-WIDTH) mod M for odd M, with A, B < M.
- Replaces the fixed 1024-bit multiplier/conditional-subtract pair with a single FSM driving one CHUNK-bit add/sub datapath.
- Area and latency trade through CHUNK.
- Sits between the RSA exponentiation controller and its operand registers.

---
 rtl/montgomery_chunked.sv | 206 ++++++++++++++++++++
 tb/tb_montgomery_chunked.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/montgomery_chunked.sv
// montgomery_chunked: radix-2 Montgomery multiplier, result = A*B*2^-WIDTH mod M.
// One FSM walks the bits of A and drives a single CHUNK-bit add/sub slice,
// so a WIDTH-bit add or subtract takes K = WIDTH/CHUNK cycles.
// Optional build macro MONT_CONST_TIME_EN: every B-add and M-add always runs
// its K cycles (adding zero when skipped), which makes latency data independent.
module montgomery_chunked #(
  parameter int WIDTH = 1024,
  parameter int CHUNK = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int K  = WIDTH / CHUNK;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int JW = (K > 1) ? $clog2(K) : 1;

`ifdef MONT_CONST_TIME_EN
  localparam bit CONST_TIME = 1'b1;
`else
  localparam bit CONST_TIME = 1'b0;
`endif

  // CHK_M never occupies a cycle of its own: it is resolved combinationally
  // into ADD_M or SHIFT at the start of the cycle in which it is reached.
  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD_B,
    S_CHK_M,
    S_ADD_M,
    S_SHIFT,
    S_SUB,
    S_FIN
  } state_t;

  state_t             r_state;
  state_t             w_next;
  state_t             w_curOp;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_m;
  logic [WIDTH+1:0]   r_c;
  logic [WIDTH-1:0]   r_d;
  logic [IW-1:0]      r_i;
  logic [JW-1:0]      r_j;
  logic               r_carry;
  logic               r_addM;

  logic               w_lastChunk;
  logic               w_lastBit;
  logic               w_addEn;
  logic [CHUNK-1:0]   w_cChunk;
  logic [CHUNK-1:0]   w_bChunk;
  logic [CHUNK-1:0]   w_mChunk;
  logic [CHUNK-1:0]   w_opChunk;
  logic [CHUNK:0]     w_sum;
  logic [1:0]         w_topSum;
  logic [CHUNK:0]     w_diff;
  logic               w_borrowOut;
  logic [WIDTH-1:0]   w_dNext;

  assign w_lastChunk = (r_j == JW'(K - 1));
  assign w_lastBit   = (r_i == IW'(WIDTH - 1));

  // Resolve the operation actually performed this cycle (zero-cycle skips and
  // the CHK_M decision), then pick the next state from it.
  always_comb begin
    w_curOp = r_state;
    w_next  = r_state;
    if (!CONST_TIME && r_state == S_ADD_B && r_j == '0 && !r_a[r_i]) begin
      w_curOp = S_CHK_M;
    end
    if (w_curOp == S_CHK_M) begin
      w_curOp = (CONST_TIME || r_c[0]) ? S_ADD_M : S_SHIFT;
    end
    case (w_curOp)
      S_IDLE:  w_next = start ? S_ADD_B : S_IDLE;
      S_ADD_B: w_next = w_lastChunk ? S_CHK_M : S_ADD_B;
      S_ADD_M: w_next = w_lastChunk ? S_SHIFT : S_ADD_M;
      S_SHIFT: w_next = w_lastBit ? S_SUB : S_ADD_B;
      S_SUB:   w_next = w_lastChunk ? S_FIN : S_SUB;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Select the current chunk of C, B and M addressed by the chunk counter.
  always_comb begin
    w_cChunk = '0;
    w_bChunk = '0;
    w_mChunk = '0;
    for (int k = 0; k < K; k++) begin
      if (r_j == JW'(k)) begin
        w_cChunk = r_c[k*CHUNK +: CHUNK];
        w_bChunk = r_b[k*CHUNK +: CHUNK];
        w_mChunk = r_m[k*CHUNK +: CHUNK];
      end
    end
  end

  // Shared slice: add B or M (or zero when the add is suppressed) and the
  // chunkwise C - M subtraction; r_carry is carry for adds, borrow for SUB.
  always_comb begin
    if (w_curOp == S_ADD_M) begin
      w_addEn = (r_j == '0) ? r_c[0] : r_addM;
    end else begin
      w_addEn = r_a[r_i];
    end
    if (!w_addEn) begin
      w_opChunk = '0;
    end else if (w_curOp == S_ADD_M) begin
      w_opChunk = w_mChunk;
    end else begin
      w_opChunk = w_bChunk;
    end
    w_sum       = {1'b0, w_cChunk} + {1'b0, w_opChunk} + {{CHUNK{1'b0}}, r_carry};
    w_topSum    = r_c[WIDTH+1:WIDTH] + {1'b0, w_sum[CHUNK]};
    w_diff      = {1'b0, w_cChunk} - {1'b0, w_mChunk} - {{CHUNK{1'b0}}, r_carry};
    w_borrowOut = w_diff[CHUNK] && (r_c[WIDTH+1:WIDTH] == 2'b00);
    w_dNext     = r_d;
    for (int k = 0; k < K; k++) begin
      if (r_j == JW'(k)) begin
        w_dNext[k*CHUNK +: CHUNK] = w_diff[CHUNK-1:0];
      end
    end
  end

  // State, operand latches, accumulator, counters and result register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_m     <= '0;
      r_c     <= '0;
      r_d     <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_carry <= 1'b0;
      r_addM  <= 1'b0;
      result  <= '0;
    end else begin
      r_state <= w_next;
      case (w_curOp)
        S_IDLE: begin
          if (start) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_m     <= in_m;
            r_c     <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_carry <= 1'b0;
          end
        end
        S_ADD_B, S_ADD_M: begin
          for (int k = 0; k < K; k++) begin
            if (r_j == JW'(k)) begin
              r_c[k*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
            end
          end
          if (w_curOp == S_ADD_M && r_j == '0) begin
            r_addM <= w_addEn;
          end
          if (w_lastChunk) begin
            r_c[WIDTH+1:WIDTH] <= w_topSum;
            r_carry            <= 1'b0;
            r_j                <= '0;
          end else begin
            r_carry <= w_sum[CHUNK];
            r_j     <= r_j + JW'(1);
          end
        end
        S_SHIFT: begin
          r_c <= r_c >> 1;
          r_i <= r_i + IW'(1);
        end
        S_SUB: begin
          r_d <= w_dNext;
          if (w_lastChunk) begin
            result  <= w_borrowOut ? r_c[WIDTH-1:0] : w_dNext;
            r_carry <= 1'b0;
            r_j     <= '0;
          end else begin
            r_carry <= w_diff[CHUNK];
            r_j     <= r_j + JW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (r_state != S_IDLE) && (r_state != S_FIN);
  assign done = (r_state == S_FIN);

endmodule

// File: tb/tb_montgomery_chunked.sv
// tb_montgomery_chunked: table-driven and randomized bench for montgomery_chunked.
// A small instance (WIDTH=8, CHUNK=4) covers directed and timing cases; a wide
// instance (WIDTH=1024, CHUNK=128) covers full-size random operands.
`timescale 1ns/1ps
module tb_montgomery_chunked;

  localparam int SW = 8;
  localparam int SC = 4;
  localparam int SK = SW / SC;
  localparam int WW = 1024;
  localparam int WC = 128;
  localparam int WK = WW / WC;
  localparam int NRAND_S = 200;
  localparam int NRAND_W = 2;
  localparam int LIMIT = 40000;

`ifdef MONT_CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif

  typedef logic [2079:0] big_t;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] m;
    logic [7:0] expRes;
    int         expLat;
  } vec_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          sStart = 1'b0;
  logic [SW-1:0] sA = '0, sB = '0, sM = '0;
  logic          sBusy, sDone;
  logic [SW-1:0] sRes;
  logic          wStart = 1'b0;
  logic [WW-1:0] wA = '0, wB = '0, wM = '0;
  logic          wBusy, wDone;
  logic [WW-1:0] wRes;

  int   checks = 0;
  int   failures = 0;
  int   subTakenCnt = 0;
  int   subSkipCnt = 0;
  vec_t vecs[NRAND_S+4];

  montgomery_chunked #(.WIDTH(SW), .CHUNK(SC)) dutS (
    .clk(clk), .resetn(resetn), .start(sStart),
    .in_a(sA), .in_b(sB), .in_m(sM),
    .busy(sBusy), .result(sRes), .done(sDone)
  );

  montgomery_chunked #(.WIDTH(WW), .CHUNK(WC)) dutW (
    .clk(clk), .resetn(resetn), .start(wStart),
    .in_a(wA), .in_b(wB), .in_m(wM),
    .busy(wBusy), .result(wRes), .done(wDone)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // A*B*2^-w mod M: reduce the product, then halve modulo M w times.
  function automatic big_t refMont(big_t a, big_t b, big_t m, int w);
    big_t x;
    x = (a * b) % m;
    for (int k = 0; k < w; k++) begin
      x = x[0] ? ((x + m) >> 1) : (x >> 1);
    end
    return x;
  endfunction

  // Expected done cycle from the bit-serial algorithm's odd-count and popcount.
  function automatic int refLatency(big_t a, big_t b, big_t m, int w, int k,
                                    output bit subTaken);
    big_t c;
    int   nOdd;
    c    = '0;
    nOdd = 0;
    for (int i = 0; i < w; i++) begin
      if (a[i]) c = c + b;
      if (c[0]) begin
        c = c + m;
        nOdd++;
      end
      c = c >> 1;
    end
    subTaken = (c >= m);
    if (CT) return w * (2 * k + 1) + k + 1;
    return k * ($countones(a) + nOdd) + w + k + 1;
  endfunction

  function automatic big_t randWide();
    big_t x;
    x = '0;
    for (int k = 0; k < WW / 32; k++) x[k*32 +: 32] = $urandom;
    return x;
  endfunction

  task automatic checkOutput(input string name, input big_t actual, input big_t expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual[127:0], expected[127:0]);
    end
  endtask

  // One operation: pulse start, then watch for done with a cycle budget.
  task automatic applyStimulus(input bit wide, input big_t a, input big_t b, input big_t m,
                               output big_t res, output int lat, output int nDone,
                               output bit protoOk);
    int   cyc;
    bit   dn, bz;
    big_t rs;
    @(negedge clk);
    if (wide) begin
      wA = a[WW-1:0]; wB = b[WW-1:0]; wM = m[WW-1:0]; wStart = 1'b1;
    end else begin
      sA = a[SW-1:0]; sB = b[SW-1:0]; sM = m[SW-1:0]; sStart = 1'b1;
    end
    @(negedge clk);
    sStart = 1'b0;
    wStart = 1'b0;
    res = '0; lat = -1; nDone = 0; protoOk = 1'b1; cyc = 1;
    while (cyc < LIMIT) begin
      dn = wide ? wDone : sDone;
      bz = wide ? wBusy : sBusy;
      rs = wide ? big_t'(wRes) : big_t'(sRes);
      if (lat < 0) begin
        if (dn) begin
          lat = cyc; res = rs; nDone++;
          if (bz) protoOk = 1'b0;
        end else if (!bz) begin
          protoOk = 1'b0;
        end
      end else begin
        if (dn) nDone++;
        if (bz || rs !== res) protoOk = 1'b0;
      end
      if (lat >= 0 && cyc >= lat + 3) break;
      @(negedge clk);
      cyc++;
    end
  endtask

  // Watchdog in case a bounded wait is ever miscoded.
  initial begin
    #20_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Main test sequence.
  initial begin
    big_t a, b, m, res;
    int   lat, nDone, cyc, expLat;
    bit   protoOk, subT, busyAfter, holdOk;

    vecs[0] = '{a: 8'd5,  b: 8'd7,  m: 8'd13, expRes: 8'd1, expLat: CT ? 43 : 19};
    vecs[1] = '{a: 8'd0,  b: 8'd12, m: 8'd13, expRes: 8'd0, expLat: CT ? 43 : 11};
    vecs[2] = '{a: 8'd12, b: 8'd12, m: 8'd13, expRes: 8'd3, expLat: CT ? 43 : 19};
    vecs[3] = '{a: 8'd1,  b: 8'd1,  m: 8'd13, expRes: 8'd3, expLat: CT ? 43 : 23};
    for (int i = 4; i < NRAND_S + 4; i++) begin
      m = big_t'(2 * $urandom_range(1, 127) + 1);
      a = big_t'($urandom) % m;
      b = big_t'($urandom) % m;
      vecs[i].a      = a[7:0];
      vecs[i].b      = b[7:0];
      vecs[i].m      = m[7:0];
      vecs[i].expRes = 8'(refMont(a, b, m, SW));
      vecs[i].expLat = refLatency(a, b, m, SW, SK, subT);
      if (subT) subTakenCnt++; else subSkipCnt++;
    end

    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_s_busy", big_t'(sBusy), '0);
    checkOutput("reset_s_done", big_t'(sDone), '0);
    checkOutput("reset_s_result", big_t'(sRes), '0);
    checkOutput("reset_w_busy", big_t'(wBusy), '0);
    checkOutput("reset_w_done", big_t'(wDone), '0);
    checkOutput("reset_w_result", big_t'(wRes), '0);
    resetn = 1'b1;

    for (int i = 0; i < NRAND_S + 4; i++) begin
      applyStimulus(1'b0, big_t'(vecs[i].a), big_t'(vecs[i].b), big_t'(vecs[i].m),
                    res, lat, nDone, protoOk);
      checkOutput($sformatf("vec%0d_result", i), res, big_t'(vecs[i].expRes));
      checkOutput($sformatf("vec%0d_latency", i), big_t'(lat), big_t'(vecs[i].expLat));
      checkOutput($sformatf("vec%0d_done_count", i), big_t'(nDone), big_t'(1));
      checkOutput($sformatf("vec%0d_busy_hold", i), big_t'(protoOk), big_t'(1));
    end

    // Start held high through the whole operation while operands change.
    @(negedge clk);
    sA = 8'd5; sB = 8'd7; sM = 8'd13; sStart = 1'b1;
    @(negedge clk);
    sA = 8'd254; sB = 8'd254; sM = 8'd255;
    cyc = 1; lat = -1; nDone = 0;
    while (lat < 0 && cyc < 1000) begin
      if (sDone) begin
        lat = cyc; nDone++;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    res = big_t'(sRes);
    @(negedge clk);
    busyAfter = sBusy;
    sStart = 1'b0;
    holdOk = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (sDone) nDone++;
      if (sRes !== 8'd1) holdOk = 1'b0;
    end
    checkOutput("held_start_result", res, big_t'(1));
    checkOutput("held_start_latency", big_t'(lat), big_t'(CT ? 43 : 19));
    checkOutput("held_start_done_count", big_t'(nDone), big_t'(1));
    checkOutput("held_start_fin_ignored", big_t'(busyAfter), '0);
    checkOutput("held_start_result_hold", big_t'(holdOk), big_t'(1));

    // Reset pulse in the middle of a long operation.
    @(negedge clk);
    sA = 8'd254; sB = 8'd254; sM = 8'd255; sStart = 1'b1;
    @(negedge clk);
    sStart = 1'b0;
    cyc = 1;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("midreset_busy_before", big_t'(sBusy), big_t'(1));
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    checkOutput("midreset_busy", big_t'(sBusy), '0);
    checkOutput("midreset_done", big_t'(sDone), '0);
    checkOutput("midreset_result", big_t'(sRes), '0);
    nDone = 0;
    repeat (60) begin
      @(negedge clk);
      if (sDone) nDone++;
    end
    checkOutput("midreset_no_done", big_t'(nDone), '0);
    applyStimulus(1'b0, big_t'(5), big_t'(7), big_t'(13), res, lat, nDone, protoOk);
    checkOutput("after_reset_result", res, big_t'(1));
    checkOutput("after_reset_latency", big_t'(lat), big_t'(CT ? 43 : 19));
    checkOutput("after_reset_done_count", big_t'(nDone), big_t'(1));

    // Full-width operands, the last one with A = B = M-1.
    for (int i = 0; i <= NRAND_W; i++) begin
      m = randWide();
      m[WW-1] = 1'b1;
      m[0] = 1'b1;
      if (i < NRAND_W) begin
        a = randWide() % m;
        b = randWide() % m;
      end else begin
        a = m - 1;
        b = m - 1;
      end
      expLat = refLatency(a, b, m, WW, WK, subT);
      if (subT) subTakenCnt++; else subSkipCnt++;
      applyStimulus(1'b1, a, b, m, res, lat, nDone, protoOk);
      checkOutput($sformatf("wide%0d_result", i), res, refMont(a, b, m, WW));
      checkOutput($sformatf("wide%0d_latency", i), big_t'(lat), big_t'(expLat));
      checkOutput($sformatf("wide%0d_done_count", i), big_t'(nDone), big_t'(1));
      checkOutput($sformatf("wide%0d_busy_hold", i), big_t'(protoOk), big_t'(1));
    end

    $display("[TB] final subtraction taken in %0d vectors, not taken in %0d",
             subTakenCnt, subSkipCnt);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
